// File: rtl/dcache_axi_read_responder_if.sv
// rtl/dcache_axi_read_responder_if.sv - AXI4 read address and read data channels
//
// Purpose: groups the AR and R channel signals between a read initiator (master)
//          and the DCache read responder (slave).
// Ports (signals):
//   ar_valid/ar_ready/ar_id/ar_addr/ar_len/ar_size/ar_burst : read address channel
//   r_valid/r_ready/r_id/r_data/r_resp/r_last                 : read data channel
interface dcache_axi_read_responder_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_BYTE  = 8,
    parameter int ID_WIDTH   = 4
) ();
    logic                     ar_valid;
    logic                     ar_ready;
    logic [ID_WIDTH-1:0]      ar_id;
    logic [ADDR_WIDTH-1:0]    ar_addr;
    logic [7:0]               ar_len;
    logic [2:0]               ar_size;
    logic [1:0]               ar_burst;

    logic                     r_valid;
    logic                     r_ready;
    logic [ID_WIDTH-1:0]      r_id;
    logic [DATA_BYTE*8-1:0]   r_data;
    logic [1:0]               r_resp;
    logic                     r_last;

    modport master (
        output ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst, r_ready,
        input  ar_ready, r_valid, r_id, r_data, r_resp, r_last
    );

    modport slave (
        input  ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst, r_ready,
        output ar_ready, r_valid, r_id, r_data, r_resp, r_last
    );
endinterface

// File: rtl/dcache_axi_read_responder.sv
// rtl/dcache_axi_read_responder.sv - AXI4 read responder streaming bursts from a sync SRAM
//
// Purpose: accepts one AR burst at a time and returns R beats read from a
//          single-port synchronous SRAM (1-cycle read latency). A 2-entry
//          buffer absorbs the SRAM latency under R backpressure.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   axi        : slave modport of the AR/R channel interface
//   mem_ren    : SRAM read enable
//   mem_raddr  : SRAM word address
//   mem_rdata  : SRAM read data, valid the cycle after mem_ren
module dcache_axi_read_responder #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_BYTE  = 8,
    parameter int ID_WIDTH   = 4,
    parameter int MEM_DEPTH  = 1024,
    localparam int MEM_AW    = $clog2(MEM_DEPTH),
    localparam int DW        = DATA_BYTE * 8
) (
    input  logic                     clk,
    input  logic                     rst,
    dcache_axi_read_responder_if.slave axi,
    output logic                     mem_ren,
    output logic [MEM_AW-1:0]        mem_raddr,
    input  logic [DW-1:0]            mem_rdata
);

    localparam int OFF = $clog2(DATA_BYTE);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [ADDR_WIDTH-1:0] DEPTH_W = ADDR_WIDTH'(MEM_DEPTH);

    typedef enum logic {IDLE, BURST} state_t;

    state_t                 state;
    logic [ID_WIDTH-1:0]    id_q;
    logic [ADDR_WIDTH-1:0]  cur_addr;
    logic [7:0]             len_q;
    logic [2:0]             size_q;
    logic [1:0]             burst_q;
    logic                   err_q;
    logic [8:0]             iss;
    logic [8:0]             ret;

    logic                   inflight;
    logic [1:0]             inflight_resp;
    logic [DW-1:0]          buf_data [2];
    logic [1:0]             buf_resp [2];
    logic                   buf_rd;
    logic                   buf_wr;
    logic [1:0]             buf_count;

    logic                   ar_hs;
    logic                   head_from_mem;
    logic                   r_valid_int;
    logic                   r_last_int;
    logic                   pop;
    logic                   push;
    logic                   pop_buf;
    logic [2:0]             occupancy;
    logic [ADDR_WIDTH-1:0]  word_idx;
    logic [1:0]             issue_resp;
    logic [DW-1:0]          rdata_masked;
    logic [DW-1:0]          head_data;
    logic [1:0]             head_resp;

    // When the buffer is empty the beat arriving from the SRAM is presented
    // directly; if it is not taken that cycle it lands in the buffer head, so
    // the R payload stays stable while stalled.
    always_comb begin
        ar_hs         = 1'b0;
        head_from_mem = (buf_count == 2'd0) && inflight;
        r_valid_int   = (buf_count != 2'd0) || inflight;
        r_last_int    = r_valid_int && (ret == {1'b0, len_q});
        pop           = r_valid_int && axi.r_ready;
        push          = inflight && !(head_from_mem && pop);
        pop_buf       = pop && (buf_count != 2'd0);
        // Occupancy the buffer will have next cycle, before any new issue.
        occupancy     = {1'b0, buf_count} + {2'b00, inflight} - {2'b00, pop};
        mem_ren       = !rst && (state == BURST) && (iss <= {1'b0, len_q})
                        && (occupancy < 3'd2);
        mem_raddr     = cur_addr[MEM_AW+OFF-1:OFF];
        word_idx      = cur_addr >> OFF;
        if (err_q) begin
            issue_resp = RESP_SLVERR;
        end else if (word_idx >= DEPTH_W) begin
            issue_resp = RESP_DECERR;
        end else begin
            issue_resp = RESP_OKAY;
        end
        rdata_masked  = (inflight_resp == RESP_OKAY) ? mem_rdata : '0;
        if (head_from_mem) begin
            head_data = rdata_masked;
            head_resp = inflight_resp;
        end else if (buf_count != 2'd0) begin
            head_data = buf_data[buf_rd];
            head_resp = buf_resp[buf_rd];
        end else begin
            head_data = '0;
            head_resp = RESP_OKAY;
        end
        if ((state == IDLE) && !rst) begin
            ar_hs = axi.ar_valid;
        end
    end

    assign axi.ar_ready = (state == IDLE) && !rst;
    assign axi.r_valid  = r_valid_int;
    assign axi.r_data   = head_data;
    assign axi.r_resp   = head_resp;
    assign axi.r_last   = r_last_int;
    assign axi.r_id     = id_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            id_q          <= '0;
            cur_addr      <= '0;
            len_q         <= '0;
            size_q        <= '0;
            burst_q       <= '0;
            err_q         <= 1'b0;
            iss           <= '0;
            ret           <= '0;
            inflight      <= 1'b0;
            inflight_resp <= RESP_OKAY;
            buf_rd        <= 1'b0;
            buf_wr        <= 1'b0;
            buf_count     <= '0;
            for (int i = 0; i < 2; i++) begin
                buf_data[i] <= '0;
                buf_resp[i] <= RESP_OKAY;
            end
        end else begin
            inflight      <= mem_ren;
            inflight_resp <= issue_resp;
            if (push) begin
                buf_data[buf_wr] <= rdata_masked;
                buf_resp[buf_wr] <= inflight_resp;
                buf_wr           <= ~buf_wr;
            end
            if (pop_buf) begin
                buf_rd <= ~buf_rd;
            end
            buf_count <= buf_count + {1'b0, push} - {1'b0, pop_buf};

            case (state)
                IDLE: begin
                    if (ar_hs) begin
                        id_q     <= axi.ar_id;
                        cur_addr <= axi.ar_addr;
                        len_q    <= axi.ar_len;
                        size_q   <= axi.ar_size;
                        burst_q  <= axi.ar_burst;
                        err_q    <= ((axi.ar_burst != BURST_FIXED) && (axi.ar_burst != BURST_INCR))
                                    || (axi.ar_size > 3'(OFF));
                        iss      <= '0;
                        ret      <= '0;
                        state    <= BURST;
                    end
                end
                BURST: begin
                    if (mem_ren) begin
                        iss <= iss + 9'd1;
                        if (burst_q == BURST_INCR) begin
                            cur_addr <= cur_addr + (ADDR_WIDTH'(1) << size_q);
                        end
                    end
                    if (pop) begin
                        ret <= ret + 9'd1;
                        if (r_last_int) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_axi_read_responder.sv
// tb/tb_dcache_axi_read_responder.sv - self-checking bench for dcache_axi_read_responder
module tb_dcache_axi_read_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_ren;
    logic [9:0]  mem_raddr;
    logic [63:0] mem_rdata;

    int total_checks = 0;
    int pass_checks  = 0;

    dcache_axi_read_responder_if #(.ADDR_WIDTH(32), .DATA_BYTE(8), .ID_WIDTH(4)) bus ();

    dcache_axi_read_responder #(
        .ADDR_WIDTH(32), .DATA_BYTE(8), .ID_WIDTH(4), .MEM_DEPTH(1024)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .axi       (bus.slave),
        .mem_ren   (mem_ren),
        .mem_raddr (mem_raddr),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] pat(input logic [31:0] i);
        return {32'hCAFE_0000 + i, 32'h5A5A_0000 ^ i};
    endfunction

    // Synchronous SRAM model: data appears the cycle after mem_ren.
    always @(posedge clk) begin
        if (mem_ren) mem_rdata <= pat({22'd0, mem_raddr});
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_checks++;
        if (act === exp) begin
            pass_checks++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [3:0]  id;
        logic        bp;
        logic [31:0] exp_word;
        logic [31:0] exp_step;
        logic        exp_slverr;
        logic [8:0]  exp_dec_beat;
    } vec_t;

    vec_t vecs [8];

    task automatic send_ar(input vec_t v, output logic ok);
        int cyc = 0;
        ok = 1'b1;
        @(negedge clk);
        bus.ar_valid = 1'b1;
        bus.ar_addr  = v.addr;
        bus.ar_len   = v.len;
        bus.ar_size  = v.size;
        bus.ar_burst = v.burst;
        bus.ar_id    = v.id;
        #1;
        while (!bus.ar_ready) begin
            @(negedge clk);
            #1;
            cyc++;
            if (cyc > 20) begin
                check("ar_ready_timeout", 64'd0, 64'd1);
                ok = 1'b0;
                bus.ar_valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        @(negedge clk);
        bus.ar_valid = 1'b0;
    endtask

    task automatic run_burst(input vec_t v);
        int          beats = int'(v.len) + 1;
        int          got = 0;
        int          issued = 0;
        int          k = 1;
        int          first_valid = -1;
        int          budget = 4 * beats + 20;
        logic        ok;
        logic        prev_stall = 1'b0;
        logic [63:0] prev_data;
        logic [1:0]  prev_resp;
        logic        prev_last;
        logic [63:0] exp_data;
        logic [1:0]  exp_resp;
        logic [31:0] word;
        send_ar(v, ok);
        if (!ok) return;
        // Now in cycle T+1 after the AR handshake.
        while (got < beats) begin
            bus.r_ready = v.bp ? ((k - 1) % 3 == 0) : 1'b1;
            #1;
            if (k == 1) begin
                check("mem_ren_at_T1", {63'd0, mem_ren}, 64'd1);
                check("ar_ready_busy", {63'd0, bus.ar_ready}, 64'd0);
            end
            if (first_valid < 0 && bus.r_valid) begin
                first_valid = k;
                check("first_rvalid_latency", 64'(k), 64'd2);
            end
            if (!(issued - got <= 2)) check("buffer_occupancy", 64'(issued - got), 64'd2);
            if (prev_stall) begin
                check("stall_valid", {63'd0, bus.r_valid}, 64'd1);
                check("stall_data", bus.r_data, prev_data);
                check("stall_resp", {62'd0, bus.r_resp}, {62'd0, prev_resp});
                check("stall_last", {63'd0, bus.r_last}, {63'd0, prev_last});
            end
            if (bus.r_valid && bus.r_ready) begin
                word = v.exp_word + v.exp_step * 32'(got);
                if (v.exp_slverr) begin
                    exp_data = 64'd0; exp_resp = 2'b10;
                end else if (got >= int'(v.exp_dec_beat)) begin
                    exp_data = 64'd0; exp_resp = 2'b11;
                end else begin
                    exp_data = pat(word); exp_resp = 2'b00;
                end
                check($sformatf("r_data[%0d]", got), bus.r_data, exp_data);
                check($sformatf("r_resp[%0d]", got), {62'd0, bus.r_resp}, {62'd0, exp_resp});
                check($sformatf("r_last[%0d]", got), {63'd0, bus.r_last}, {63'd0, got == beats - 1});
                check($sformatf("r_id[%0d]", got), {60'd0, bus.r_id}, {60'd0, v.id});
                got++;
            end
            prev_stall = bus.r_valid && !bus.r_ready;
            prev_data  = bus.r_data;
            prev_resp  = bus.r_resp;
            prev_last  = bus.r_last;
            if (mem_ren) issued++;
            @(negedge clk);
            k++;
            if (k > budget) begin
                check("burst_timeout", 64'(got), 64'(beats));
                return;
            end
        end
        #1;
        check("issue_count", 64'(issued), 64'(beats));
        check("ar_ready_after_last", {63'd0, bus.ar_ready}, 64'd1);
        check("r_valid_after_last", {63'd0, bus.r_valid}, 64'd0);
        bus.r_ready = 1'b0;
    endtask

    initial begin
        vec_t v;
        int   got;
        int   cyc;
        logic ok;

        //          addr          len    size  burst  id     bp    word      step  slv   dec
        vecs[0] = '{32'h0000_0100, 8'd7,   3'd3, 2'b01, 4'h3, 1'b0, 32'h20,  32'd1, 1'b0, 9'd511};
        vecs[1] = '{32'h0000_0100, 8'd7,   3'd3, 2'b01, 4'h5, 1'b1, 32'h20,  32'd1, 1'b0, 9'd511};
        vecs[2] = '{32'h0000_0200, 8'd3,   3'd3, 2'b10, 4'h1, 1'b0, 32'h40,  32'd1, 1'b1, 9'd511};
        vecs[3] = '{32'h0000_0200, 8'd3,   3'd4, 2'b01, 4'h2, 1'b0, 32'h40,  32'd1, 1'b1, 9'd511};
        vecs[4] = '{32'h0000_1FF0, 8'd3,   3'd3, 2'b01, 4'h4, 1'b1, 32'd1022, 32'd1, 1'b0, 9'd2};
        vecs[5] = '{32'h0000_0040, 8'd3,   3'd3, 2'b00, 4'hA, 1'b0, 32'd8,   32'd0, 1'b0, 9'd511};
        vecs[6] = '{32'h0000_03F8, 8'd0,   3'd3, 2'b01, 4'h7, 1'b1, 32'h7F,  32'd1, 1'b0, 9'd511};
        vecs[7] = '{32'h0000_0000, 8'd255, 3'd3, 2'b01, 4'hF, 1'b0, 32'd0,   32'd1, 1'b0, 9'd511};

        rst = 1'b1;
        bus.ar_valid = 1'b0;
        bus.ar_addr  = '0;
        bus.ar_len   = '0;
        bus.ar_size  = '0;
        bus.ar_burst = '0;
        bus.ar_id    = '0;
        bus.r_ready  = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_ar_ready", {63'd0, bus.ar_ready}, 64'd0);
        check("rst_r_valid", {63'd0, bus.r_valid}, 64'd0);
        check("rst_r_last", {63'd0, bus.r_last}, 64'd0);
        check("rst_r_data", bus.r_data, 64'd0);
        check("rst_r_resp", {62'd0, bus.r_resp}, 64'd0);
        check("rst_r_id", {60'd0, bus.r_id}, 64'd0);
        check("rst_mem_ren", {63'd0, mem_ren}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("ar_ready_after_rst", {63'd0, bus.ar_ready}, 64'd1);

        for (int i = 0; i < 8; i++) begin
            run_burst(vecs[i]);
        end

        // Reset at beat 3 of a 16-beat burst, then a fresh burst.
        v = '{32'h0000_0080, 8'd15, 3'd3, 2'b01, 4'h6, 1'b0, 32'h10, 32'd1, 1'b0, 9'd511};
        send_ar(v, ok);
        bus.r_ready = 1'b1;
        got = 0;
        cyc = 0;
        while (ok && got < 3) begin
            #1;
            if (bus.r_valid) got++;
            @(negedge clk);
            cyc++;
            if (cyc > 30) begin
                check("midburst_timeout", 64'(got), 64'd3);
                ok = 1'b0;
            end
        end
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("midrst_r_valid", {63'd0, bus.r_valid}, 64'd0);
        check("midrst_mem_ren", {63'd0, mem_ren}, 64'd0);
        check("midrst_ar_ready", {63'd0, bus.ar_ready}, 64'd0);
        rst = 1'b0;
        bus.r_ready = 1'b0;
        #1;
        check("postrst_r_valid", {63'd0, bus.r_valid}, 64'd0);
        v.len = 8'd3;
        v.id  = 4'h9;
        run_burst(v);

        $display("%0d/%0d checks passed", pass_checks, total_checks);
        $finish;
    end

endmodule

// File: doc/dcache_axi_read_responder.md
Name: dcache_axi_read_responder

Overview:
- AXI4 read-channel responder (slave end) for the DCache refill path: accepts AR bursts from the miss unit's read initiator and streams R beats back from a synchronous single-port data SRAM.
- Serves as the memory-side model and test target for DCache refill, and as the read port of the on-chip scratch RAM behind the DCache AXI bus.
- Handles one burst at a time; a 2-entry output buffer absorbs the SRAM's 1-cycle read latency under R backpressure.

Parameters:
- ADDR_WIDTH, 32, AR address width.
- DATA_BYTE, 8, bytes per beat; R data width is DATA_BYTE*8.
- ID_WIDTH, 4, AXI ID width.
- MEM_DEPTH, 1024, SRAM words of DATA_BYTE bytes; MEM_AW = clog2(MEM_DEPTH).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ar_valid  in  1  AR valid
- ar_ready  out  1  AR ready
- ar_id  in  ID_WIDTH  AR id
- ar_addr  in  ADDR_WIDTH  AR byte address
- ar_len  in  8  beats-1
- ar_size  in  3  log2 bytes per beat
- ar_burst  in  2  00 FIXED, 01 INCR, 10 WRAP
- r_valid  out  1  R valid
- r_ready  in  1  R ready
- r_id  out  ID_WIDTH  returned id
- r_data  out  DATA_BYTE*8  beat data
- r_resp  out  2  00 OKAY, 10 SLVERR, 11 DECERR
- r_last  out  1  final beat
- mem_ren  out  1  SRAM read enable
- mem_raddr  out  MEM_AW  SRAM word address
- mem_rdata  in  DATA_BYTE*8  SRAM data, valid the cycle after mem_ren

Behaviour:
- Reset (synchronous, active-high): state IDLE; ar_ready=0 while rst is high; r_valid=0, r_last=0, r_data=0, r_resp=0, r_id=0, mem_ren=0; counters and buffer cleared. ar_ready=1 in the first cycle after rst deasserts.
- States IDLE and BURST.
- IDLE: ar_ready=1. On ar_valid&ar_ready, latch id, addr, len, size, burst; compute err = (burst not 00/01) | (size > clog2(DATA_BYTE)); go to BURST; ar_ready=0 from the next cycle.
- BURST: issue counter iss (0..len) and return counter ret (0..len), both 9-bit so len=255 does not wrap.
- Issue rule: mem_ren=1 when iss<=len and (buf_count + inflight - pop) < 2, where pop = r_valid&r_ready this cycle and inflight = mem_ren in the previous cycle.
- mem_raddr = cur_addr[MEM_AW+clog2(DATA_BYTE)-1 : clog2(DATA_BYTE)].
- Address update after each issue: INCR adds 1<<size, wraps modulo 2^ADDR_WIDTH, no 4KB check; FIXED leaves the address unchanged.
- Per-beat resp: err gives SLVERR; else a word index >= MEM_DEPTH gives DECERR; else OKAY.
- Beats carrying SLVERR or DECERR return r_data=0 and still consume issue slots.
- Out-of-range beats still drive mem_ren; their returned data is replaced by 0.
- Buffer: 2-entry FIFO of {data, resp}. The entry is written the cycle after mem_ren. r_valid = buffer non-empty. r_data/r_resp come from the buffer head.
- r_last = (ret==len). r_id = latched id.
- While r_valid & ~r_ready, r_data, r_resp, r_last and r_id are held stable.
- Completion: on the handshake with r_last, go to IDLE; ar_ready=1 in the next cycle.
- Latency: AR handshake at cycle T gives mem_ren at T+1 and r_valid at T+2. With r_ready held high, one beat per cycle with no bubbles.
- Back-to-back bursts: the next AR is accepted at the earliest one cycle after the last R handshake.
- Reset mid-burst: the burst is abandoned, buffer and in-flight data are discarded, and r_valid=0 in the cycle after rst.
- len=0: single beat with r_last=1.

Test Plan:
- Single INCR burst: ar_addr=0x100, len=7, size=3, r_ready=1 -> 8 beats of mem[0x20..0x27], all OKAY; first r_valid 2 cycles after AR; r_last only on beat 8; ar_ready back 1 cycle later.
- Backpressure: same burst with r_ready toggling 1,0,0,1,... -> no beat lost or duplicated, data stable while stalled, at most 2 beats buffered, mem_ren stalls.
- Error bursts: ar_burst=10 len=3 -> 4 beats, SLVERR, data 0, last on beat 4; ar_size=4 -> 4 beats, SLVERR.
- Decode error: ar_addr=(MEM_DEPTH-2)*8, len=3 -> OKAY, OKAY, DECERR, DECERR.
- FIXED burst: addr 0x40, len=3 -> 4 beats of mem[8]; r_id echoes ar_id=0xA.
- Reset at beat 3 of a len=15 burst -> r_valid=0 the next cycle; a fresh AR after reset returns correct data starting from beat 0.
